// File: rtl/rib_arbiter.sv
// Round-robin arbiter for the RIB interconnect: one grant at a time with locked bursts,
// slave-stall timeout and a combinational hold flag that stalls the losing masters.
module rib_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MID_W       = 2,
    parameter int TIMEOUT     = 16,
    parameter int MAX_BURST   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [NUM_MASTERS-1:0] lock_i,
    input  logic                   slv_ready_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [MID_W-1:0]       grant_id_o,
    output logic                   grant_valid_o,
    output logic                   hold_flag_o,
    output logic                   timeout_o
);
    localparam int WAIT_W  = $clog2(TIMEOUT);
    localparam int BURST_W = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {IDLE, GRANT, TOUT} state_t;

    state_t                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [MID_W-1:0]       gid_q;
    logic [MID_W-1:0]       last_id_q;
    logic                   valid_q;
    logic                   tout_q;
    logic [WAIT_W-1:0]      wait_q;
    logic [BURST_W-1:0]     burst_q;

    logic [NUM_MASTERS-1:0] others_d;
    logic [MID_W:0]         pick_all_d;
    logic [MID_W:0]         pick_oth_d;
    logic                   keep_d;

    // Returns {found, index}: first set bit of mask after position last, wrapping around.
    function automatic logic [MID_W:0] rr_pick(input logic [NUM_MASTERS-1:0] mask,
                                               input logic [MID_W-1:0] last);
        logic [MID_W:0] res;
        int             idx;
        res = '0;
        for (int off = NUM_MASTERS; off >= 1; off--) begin
            idx = (int'(last) + off) % NUM_MASTERS;
            if (mask[idx]) res = {1'b1, MID_W'(idx)};
        end
        return res;
    endfunction

    always_comb begin
        others_d   = req_i & ~grant_q;
        pick_all_d = rr_pick(req_i, last_id_q);
        pick_oth_d = rr_pick(others_d, gid_q);
        keep_d     = slv_ready_i & lock_i[gid_q] & req_i[gid_q] &
                     ((burst_q < BURST_W'(MAX_BURST - 1)) | ~(|others_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gid_q     <= '0;
            valid_q   <= 1'b0;
            tout_q    <= 1'b0;
            wait_q    <= '0;
            burst_q   <= '0;
            last_id_q <= MID_W'(NUM_MASTERS - 1);
        end else begin
            tout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    wait_q  <= '0;
                    burst_q <= '0;
                    if (pick_all_d[MID_W]) begin
                        state_q <= GRANT;
                        gid_q   <= pick_all_d[MID_W-1:0];
                        grant_q <= NUM_MASTERS'(1) << pick_all_d[MID_W-1:0];
                        valid_q <= 1'b1;
                    end else begin
                        grant_q <= '0;
                        gid_q   <= '0;
                        valid_q <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!req_i[gid_q] || (slv_ready_i && !keep_d)) begin
                        // Release: others first, then a lone unlocked owner is regranted gap-free.
                        last_id_q <= gid_q;
                        wait_q    <= '0;
                        burst_q   <= '0;
                        if (pick_oth_d[MID_W]) begin
                            gid_q   <= pick_oth_d[MID_W-1:0];
                            grant_q <= NUM_MASTERS'(1) << pick_oth_d[MID_W-1:0];
                        end else if (!req_i[gid_q]) begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            gid_q   <= '0;
                            valid_q <= 1'b0;
                        end
                    end else if (slv_ready_i) begin
                        wait_q <= '0;
                        if (burst_q < BURST_W'(MAX_BURST - 1)) burst_q <= burst_q + 1'b1;
                    end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        state_q   <= TOUT;
                        last_id_q <= gid_q;
                        grant_q   <= '0;
                        gid_q     <= '0;
                        valid_q   <= 1'b0;
                        tout_q    <= 1'b1;
                        wait_q    <= '0;
                        burst_q   <= '0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    gid_q   <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign grant_id_o    = gid_q;
    assign grant_valid_o = valid_q;
    assign timeout_o     = tout_q;
    assign hold_flag_o   = |(req_i & ~grant_q);
endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter: round-robin order, locked bursts, timeout, abandon and reset.
module tb_rib_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_i;
    logic [3:0] lock_i;
    logic       slv_ready_i;
    logic [3:0] grant_o;
    logic [1:0] grant_id_o;
    logic       grant_valid_o;
    logic       hold_flag_o;
    logic       timeout_o;

    int tests = 0;
    int fails = 0;

    rib_arbiter #(.NUM_MASTERS(4), .MID_W(2), .TIMEOUT(16), .MAX_BURST(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .lock_i       (lock_i),
        .slv_ready_i  (slv_ready_i),
        .grant_o      (grant_o),
        .grant_id_o   (grant_id_o),
        .grant_valid_o(grant_valid_o),
        .hold_flag_o  (hold_flag_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_i = 4'b0; lock_i = 4'b0; slv_ready_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_i = 4'b0; lock_i = 4'b0; slv_ready_i = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_grant", 8'(grant_o), 8'h00);
        check("rst_gid", 8'(grant_id_o), 8'h00);
        check("rst_valid", 8'(grant_valid_o), 8'h00);
        check("rst_tout", 8'(timeout_o), 8'h00);
        check("rst_hold", 8'(hold_flag_o), 8'h00);

        // Two requesters alternate, first grant one cycle after request
        req_i = 4'b0110; slv_ready_i = 1'b1;
        #1 check("t1_hold_pre", 8'(hold_flag_o), 8'h01);
        check("t1_nogrant_yet", 8'(grant_o), 8'h00);
        step(); check("t1_g0", 8'(grant_o), 8'h02); check("t1_h0", 8'(hold_flag_o), 8'h01);
        step(); check("t1_g1", 8'(grant_o), 8'h04); check("t1_h1", 8'(hold_flag_o), 8'h01);
        step(); check("t1_g2", 8'(grant_o), 8'h02);
        step(); check("t1_g3", 8'(grant_o), 8'h04);

        // All four request: 0,1,2,3,0 with no idle cycle
        do_reset();
        req_i = 4'b1111; slv_ready_i = 1'b1;
        step(); check("t2_id0", 8'(grant_id_o), 8'h00); check("t2_v0", 8'(grant_valid_o), 8'h01);
        step(); check("t2_id1", 8'(grant_id_o), 8'h01); check("t2_v1", 8'(grant_valid_o), 8'h01);
        step(); check("t2_id2", 8'(grant_id_o), 8'h02);
        step(); check("t2_id3", 8'(grant_id_o), 8'h03); check("t2_g3", 8'(grant_o), 8'h08);
        step(); check("t2_id4", 8'(grant_id_o), 8'h00); check("t2_v4", 8'(grant_valid_o), 8'h01);

        // Locked burst: M1 keeps 8 transfers then yields to M0
        do_reset();
        req_i = 4'b0010; lock_i = 4'b0010; slv_ready_i = 1'b1;
        step(); check("t3_b0", 8'(grant_o), 8'h02);
        req_i = 4'b0011;
        for (int i = 1; i < 8; i++) begin
            step(); check($sformatf("t3_b%0d", i), 8'(grant_o), 8'h02);
        end
        step(); check("t3_yield", 8'(grant_o), 8'h01); check("t3_yield_id", 8'(grant_id_o), 8'h00);

        // Timeout on M2, then M0 wins
        do_reset();
        req_i = 4'b0100;
        step(); check("t4_g", 8'(grant_o), 8'h04);
        req_i = 4'b0101;
        for (int i = 1; i < 16; i++) begin
            step();
            if (grant_o !== 4'b0100 || timeout_o !== 1'b0)
                check($sformatf("t4_wait%0d", i), {grant_o, 3'b0, timeout_o}, 8'h40);
        end
        check("t4_wait_end", 8'(grant_o), 8'h04);
        step(); check("t4_tout", 8'(timeout_o), 8'h01); check("t4_tout_grant", 8'(grant_o), 8'h00);
        check("t4_tout_valid", 8'(grant_valid_o), 8'h00);
        step(); check("t4_idle_tout", 8'(timeout_o), 8'h00); check("t4_idle_grant", 8'(grant_o), 8'h00);
        step(); check("t4_next", 8'(grant_o), 8'h01);

        // Ready arriving on the last wait cycle wins over timeout
        do_reset();
        req_i = 4'b0100;
        step();
        for (int i = 1; i < 16; i++) step();
        slv_ready_i = 1'b1;
        step(); check("t4b_no_tout", 8'(timeout_o), 8'h00); check("t4b_regrant", 8'(grant_o), 8'h04);

        // Abandon: M3 drops request, M0 granted next cycle
        do_reset();
        req_i = 4'b1000;
        step(); check("t5_g3", 8'(grant_o), 8'h08); check("t5_id3", 8'(grant_id_o), 8'h03);
        req_i = 4'b0001;
        #1 check("t5_hold", 8'(hold_flag_o), 8'h01);
        step(); check("t5_g0", 8'(grant_o), 8'h01); check("t5_id0", 8'(grant_id_o), 8'h00);

        // Reset during a locked burst
        do_reset();
        req_i = 4'b0001; lock_i = 4'b0001; slv_ready_i = 1'b1;
        step(); step(); step();
        check("t6_burst", 8'(grant_o), 8'h01);
        rst = 1'b1;
        step(); check("t6_rst_grant", 8'(grant_o), 8'h00); check("t6_rst_valid", 8'(grant_valid_o), 8'h00);
        rst = 1'b0;
        step(); check("t6_regrant", 8'(grant_o), 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
